// File: rtl/dot_channel_array_pkg.sv
// Shared constants, state encoding and width helpers for the dot-product channel engine.
package dot_channel_array_pkg;

  localparam int DATA_LEN   = 18;
  localparam int FRAC_LEN   = 12;
  localparam int LAYER_ID_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Index width that stays legal when a dimension collapses to a single entry.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dot_tree.sv
// N_IN signed multipliers feeding an adder tree; the sum is registered (latency 1).
module dot_tree
  import dot_channel_array_pkg::*;
#(
  parameter int DATA_W = DATA_LEN,
  parameter int N_IN   = 36,
  parameter int SUM_W  = 2*DATA_LEN + 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [N_IN*DATA_W-1:0]   a_i,
  input  logic [N_IN*DATA_W-1:0]   b_i,
  output logic signed [SUM_W-1:0]  sum_o
);

  localparam int PROD_W = 2*DATA_W;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [SUM_W-1:0]  sum_s;

  // Full-precision products summed in the widened accumulator width.
  always_comb begin
    prod_s = '0;
    sum_s  = '0;
    for (int i = 0; i < N_IN; i++) begin
      prod_s = PROD_W'($signed(a_i[i*DATA_W +: DATA_W])) *
               PROD_W'($signed(b_i[i*DATA_W +: DATA_W]));
      sum_s  = sum_s + SUM_W'(prod_s);
    end
  end

  // Output register of the tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_o <= '0;
    end else if (en_i) begin
      sum_o <= sum_s;
    end
  end

endmodule

// File: rtl/dot_channel_array.sv
// N_CH dot-product channels time-multiplexed over one dot_tree, with per-channel
// phase accumulation, round/saturate post stage and per-layer ReLU.
module dot_channel_array
  import dot_channel_array_pkg::*;
#(
  parameter int DATA_W  = DATA_LEN,
  parameter int FRAC_W  = FRAC_LEN,
  parameter int N_IN    = 36,
  parameter int N_CH    = 4,
  parameter int N_PHASE = 8,
  parameter int N_LAYER = 16,
  parameter logic [N_LAYER-1:0] RELU_MASK = {N_LAYER{1'b0}},
  localparam int CS_W  = clog2_min1(N_LAYER),
  localparam int PH_W  = clog2_min1(N_PHASE),
  localparam int CH_W  = clog2_min1(N_CH),
  localparam int VEC_W = N_IN*DATA_W,
  localparam int SUM_W = 2*DATA_W + clog2_min1(N_IN),
  localparam int ACC_W = SUM_W + PH_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dc_load,
  input  logic [CS_W-1:0]   cs,
  input  logic [PH_W-1:0]   phase,
  input  logic              last,
  input  logic [VEC_W-1:0]  d,
  input  logic              ws_load,
  input  logic [CH_W-1:0]   w_ch,
  input  logic [PH_W-1:0]   w_phase,
  input  logic [VEC_W-1:0]  w_d,
  output logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] q,
  output logic [CH_W-1:0]   q_ch,
  output logic              sat,
  output logic              w_err
);

  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(64'sd1 <<< (FRAC_W-1));
  localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
  localparam logic signed [ACC_W:0] SAT_MIN  = ~SAT_MAX;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                accept_s, issue_s;
  logic [VEC_W-1:0]    d_q;
  logic [CS_W-1:0]     cs_q;
  logic [PH_W-1:0]     phase_q;
  logic                last_q;
  logic [VEC_W-1:0]    wmem_q [N_CH][N_PHASE];
  logic signed [SUM_W-1:0] sum_s;
  logic                s1_vld_q, s1_first_q, s1_last_q, s1_relu_q;
  logic [CH_W-1:0]     s1_ch_q;
  logic signed [ACC_W-1:0] acc_q [N_CH];
  logic signed [ACC_W-1:0] acc_new_s;
  logic [DATA_W:0]     post_s;
  logic                valid_q, sat_q, w_err_q;
  logic [DATA_W-1:0]   res_q;
  logic [CH_W-1:0]     res_ch_q;

  // Round half up, saturate to DATA_W, then optional ReLU; returns {sat, value}.
  function automatic logic [DATA_W:0] post_f(input logic signed [ACC_W-1:0] x,
                                             input logic relu);
    logic signed [ACC_W:0] r;
    logic [DATA_W-1:0]     y;
    logic                  s;
    r = $signed({x[ACC_W-1], x}) + RND_HALF;
    r = r >>> FRAC_W;
    if (r > SAT_MAX) begin
      y = SAT_MAX[DATA_W-1:0];
      s = 1'b1;
    end else if (r < SAT_MIN) begin
      y = SAT_MIN[DATA_W-1:0];
      s = 1'b1;
    end else begin
      y = r[DATA_W-1:0];
      s = 1'b0;
    end
    y = (relu && y[DATA_W-1]) ? {DATA_W{1'b0}} : y;
    return {s, y};
  endfunction

  // FSM next state: accept in IDLE, then issue one channel per RUN cycle.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    accept_s = 1'b0;
    issue_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dc_load) begin
          accept_s = 1'b1;
          state_d  = ST_RUN;
          ch_d     = '0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        issue_s = 1'b1;
        if (ch_q == CH_W'(N_CH-1)) begin
          state_d = ST_IDLE;
          ch_d    = '0;
        end else begin
          ch_d    = ch_q + CH_W'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end
    endcase
  end

  // FSM state and operands latched on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      d_q     <= '0;
      cs_q    <= '0;
      phase_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      if (accept_s) begin
        d_q     <= d;
        cs_q    <= cs;
        phase_q <= phase;
        last_q  <= last;
      end
    end
  end

  assign ready = (state_q == ST_IDLE);

  // Weight buffer has no reset; writes land only while idle.
  always_ff @(posedge clk) begin
    if (ws_load && ready) begin
      wmem_q[w_ch][w_phase] <= w_d;
    end
  end

  // Dropped weight writes raise a one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_err_q <= 1'b0;
    end else begin
      w_err_q <= ws_load & ~ready;
    end
  end

  dot_tree #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN),
    .SUM_W  (SUM_W)
  ) u_tree (
    .clk   (clk),
    .rst   (rst),
    .en_i  (issue_s),
    .a_i   (d_q),
    .b_i   (wmem_q[ch_q][phase_q]),
    .sum_o (sum_s)
  );

  // Stage-1 side tags travel alongside the tree output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_relu_q  <= 1'b0;
    end else begin
      s1_vld_q <= issue_s;
      if (issue_s) begin
        s1_ch_q    <= ch_q;
        s1_first_q <= (phase_q == '0);
        s1_last_q  <= last_q;
        s1_relu_q  <= RELU_MASK[cs_q];
      end
    end
  end

  // Phase 0 restarts the channel's accumulator; later phases add onto it.
  always_comb begin
    acc_new_s = '0;
    if (s1_first_q) begin
      acc_new_s = ACC_W'(sum_s);
    end else begin
      acc_new_s = acc_q[s1_ch_q] + ACC_W'(sum_s);
    end
    post_s = post_f(acc_new_s, s1_relu_q);
  end

  // Accumulator bank and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        acc_q[i] <= '0;
      end
      valid_q  <= 1'b0;
      res_q    <= '0;
      res_ch_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      valid_q <= s1_vld_q & s1_last_q;
      if (s1_vld_q) begin
        acc_q[s1_ch_q] <= acc_new_s;
        if (s1_last_q) begin
          res_q    <= post_s[DATA_W-1:0];
          sat_q    <= post_s[DATA_W];
          res_ch_q <= s1_ch_q;
        end
      end
    end
  end

  assign valid = valid_q;
  assign q     = res_q;
  assign q_ch  = res_ch_q;
  assign sat   = sat_q;
  assign w_err = w_err_q;

endmodule

// File: tb/tb_dot_channel_array.sv
// Directed bench for dot_channel_array with a reference model feeding an expected-result queue.
module tb_dot_channel_array;

  localparam int DATA_W  = 18;
  localparam int FRAC_W  = 12;
  localparam int N_IN    = 36;
  localparam int N_CH    = 4;
  localparam int N_PHASE = 8;
  localparam int N_LAYER = 16;
  localparam logic [15:0] RELU = 16'h0008;
  localparam int VEC_W   = N_IN*DATA_W;

  logic clk = 1'b0;
  logic rst, dc_load, last, ws_load;
  logic [3:0] cs;
  logic [2:0] phase, w_phase;
  logic [1:0] w_ch;
  logic [VEC_W-1:0] d, w_d;
  logic ready, valid, sat, w_err;
  logic [DATA_W-1:0] q;
  logic [1:0] q_ch;

  dot_channel_array #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_IN(N_IN), .N_CH(N_CH),
    .N_PHASE(N_PHASE), .N_LAYER(N_LAYER), .RELU_MASK(RELU)
  ) dut (
    .clk(clk), .rst(rst), .dc_load(dc_load), .cs(cs), .phase(phase), .last(last),
    .d(d), .ws_load(ws_load), .w_ch(w_ch), .w_phase(w_phase), .w_d(w_d),
    .ready(ready), .valid(valid), .q(q), .q_ch(q_ch), .sat(sat), .w_err(w_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              due;
    logic [1:0]      ch;
    logic [DATA_W-1:0] q;
    logic            sat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic signed [DATA_W-1:0] w_m [N_CH][N_PHASE][N_IN];
  longint acc_m [N_CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Every valid must match the oldest outstanding expectation, including its cycle.
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("q_ch", q_ch, e.ch);
        chk("sat", sat, e.sat);
        chk("latency", cyc, e.due);
      end
    end
  end

  function automatic logic [VEC_W-1:0] fill(input logic [DATA_W-1:0] v);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] rnd_vec();
    logic [VEC_W-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return r;
  endfunction

  task automatic model_op(input logic [3:0] c_s, input logic [2:0] ph, input logic l,
                          input logic [VEC_W-1:0] dv, input int e0);
    for (int c = 0; c < N_CH; c++) begin
      longint s = 0;
      longint r;
      exp_t x;
      for (int i = 0; i < N_IN; i++) begin
        logic signed [DATA_W-1:0] di;
        di = dv[i*DATA_W +: DATA_W];
        s += longint'(di) * longint'(w_m[c][ph][i]);
      end
      acc_m[c] = (ph == 3'd0) ? s : acc_m[c] + s;
      if (l) begin
        r = (acc_m[c] + (64'sd1 <<< (FRAC_W-1))) >>> FRAC_W;
        x.sat = 1'b0;
        if (r > 64'sd131071) begin r = 64'sd131071; x.sat = 1'b1; end
        if (r < -64'sd131072) begin r = -64'sd131072; x.sat = 1'b1; end
        if (RELU[c_s] && r < 0) r = 0;
        x.q   = r[DATA_W-1:0];
        x.ch  = 2'(c);
        x.due = e0 + 3 + c;
        sb.push_back(x);
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", ready, 1'b1);
  endtask

  task automatic set_w(input int c, input int p, input logic [VEC_W-1:0] v);
    ws_load = 1'b1;
    w_ch    = 2'(c);
    w_phase = 3'(p);
    w_d     = v;
    for (int i = 0; i < N_IN; i++) w_m[c][p][i] = v[i*DATA_W +: DATA_W];
  endtask

  task automatic wr_w(input int c, input int p, input logic [VEC_W-1:0] v);
    wait_ready();
    set_w(c, p, v);
    @(negedge clk);
    ws_load = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] c_s, input logic [2:0] ph, input logic l,
                       input logic [VEC_W-1:0] dv);
    wait_ready();
    cs = c_s; phase = ph; last = l; d = dv; dc_load = 1'b1;
    model_op(c_s, ph, l, dv, cyc);
    @(negedge clk);
    dc_load = 1'b0;
    ws_load = 1'b0;
  endtask

  initial begin
    logic [VEC_W-1:0] one_v;
    int n;
    rst = 1'b1; dc_load = 1'b0; ws_load = 1'b0; cs = 4'd0; phase = 3'd0; last = 1'b0;
    d = '0; w_ch = 2'd0; w_phase = 3'd0; w_d = '0;
    for (int c = 0; c < N_CH; c++) acc_m[c] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", valid, 1'b0);
    chk("rst_q", q, 18'h00000);
    chk("rst_q_ch", q_ch, 2'd0);
    chk("rst_sat", sat, 1'b0);
    chk("rst_w_err", w_err, 1'b0);

    // 0.5 weights on phases 0 and 1, all-ones input: 18.0, then 36.0 saturating
    for (int c = 0; c < N_CH; c++) wr_w(c, 0, fill(18'h00800));
    for (int c = 0; c < N_CH; c++) wr_w(c, 1, fill(18'h00800));
    do_op(4'd0, 3'd0, 1'b1, fill(18'h01000));
    do_op(4'd0, 3'd0, 1'b0, fill(18'h01000));
    do_op(4'd0, 3'd1, 1'b1, fill(18'h01000));

    // -0.5 weights: layer 0 passes negatives, layer 3 clamps them
    for (int c = 0; c < N_CH; c++) wr_w(c, 0, fill(18'h3F800));
    do_op(4'd0, 3'd0, 1'b1, fill(18'h01000));
    do_op(4'd3, 3'd0, 1'b1, fill(18'h01000));

    // Rounding with a single LSB input
    one_v = '0;
    one_v[DATA_W-1:0] = 18'h00001;
    do_op(4'd0, 3'd0, 1'b1, one_v);
    for (int c = 0; c < N_CH; c++) wr_w(c, 0, fill(18'h00800));
    do_op(4'd0, 3'd0, 1'b1, one_v);

    // Weight write and op on the same idle edge
    wait_ready();
    set_w(2, 0, fill(18'h00400));
    do_op(4'd0, 3'd0, 1'b1, fill(18'h01000));

    // Write and dc_load while busy are dropped/ignored
    do_op(4'd0, 3'd0, 1'b1, fill(18'h01000));
    ws_load = 1'b1; w_ch = 2'd0; w_phase = 3'd0; w_d = fill(18'h3F000);
    dc_load = 1'b1; cs = 4'd5; phase = 3'd3; last = 1'b1;
    @(negedge clk);
    ws_load = 1'b0; dc_load = 1'b0;
    chk("w_err_pulse", w_err, 1'b1);
    chk("busy_not_ready", ready, 1'b0);
    @(negedge clk);
    chk("w_err_clear", w_err, 1'b0);
    do_op(4'd0, 3'd0, 1'b1, fill(18'h01000));

    // Reset two edges into an op aborts it and clears accumulators
    do_op(4'd0, 3'd0, 1'b1, fill(18'h01000));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < N_CH; c++) acc_m[c] = 0;
    chk("post_rst_ready", ready, 1'b1);
    chk("post_rst_valid", valid, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("aborted_no_valid", valid, 1'b0);
    end
    do_op(4'd0, 3'd1, 1'b1, fill(18'h01000));

    // Random two-phase ops across layers
    for (int k = 1; k < 4; k++) begin
      for (int c = 0; c < N_CH; c++) wr_w(c, 2, rnd_vec());
      for (int c = 0; c < N_CH; c++) wr_w(c, 3, rnd_vec());
      do_op(4'(k), 3'd2, 1'b0, rnd_vec());
      do_op(4'(k), 3'd3, 1'b1, rnd_vec());
    end

    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_channel_array.md
Name: dot_channel_array

Overview:
- Parametrised successor of the single dot-product channel: computes N_CH fixed-point dot products of one N_IN-element input vector against per-channel, per-phase weight vectors.
- Channels are time-multiplexed through one shared multiply/adder-tree datapath, one channel per cycle.
- Partial sums accumulate across input phases, with rounding, saturation and per-layer optional ReLU on the final result.
- Sits between the layer state machine (supplies cs, phase) and the feature-map buffer.

Parameters:
- DATA_W, 18, signed fixed-point word width.
- FRAC_W, 12, fractional bits (1.0 = 18'h01000).
- N_IN, 36, elements per input vector.
- N_CH, 4, output channels (>=1).
- N_PHASE, 8, phases accumulated per output.
- N_LAYER, 16, layer IDs carried on cs.
- RELU_MASK, 16'h0000, bit L set enables ReLU for layer L.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- dc_load  in  1  start dot-product op; accepted only when ready=1.
- cs  in  $clog2(N_LAYER)  layer ID, latched on accept.
- phase  in  $clog2(N_PHASE)  phase index, latched on accept.
- last  in  1  final phase of this output, latched on accept.
- d  in  N_IN*DATA_W  input vector, element i at bits [i*DATA_W +: DATA_W].
- ws_load  in  1  weight write strobe.
- w_ch  in  $clog2(N_CH)  weight write channel.
- w_phase  in  $clog2(N_PHASE)  weight write phase.
- w_d  in  N_IN*DATA_W  weight vector.
- ready  out  1  high in IDLE.
- valid  out  1  q/q_ch/sat hold a final result this cycle.
- q  out  DATA_W  result.
- q_ch  out  $clog2(N_CH)  channel of q.
- sat  out  1  q was saturated.
- w_err  out  1  one-cycle pulse: ws_load dropped because ready=0.

Behaviour:
- Reset (synchronous): state IDLE, valid=0, q=0, q_ch=0, sat=0, w_err=0, all accumulators 0, pipeline valids 0. The weight buffer is not reset. Reset mid-op aborts the op; no valid follows.
- FSM IDLE/RUN:
  - IDLE: ready=1. If dc_load is sampled at edge E0, latch d, cs, phase and last; go to RUN with ch=0.
  - RUN: each cycle issue channel ch; ch increments. After issuing ch=N_CH-1, return to IDLE at edge E0+N_CH. Next accept no earlier than E0+N_CH+1.
- dc_load while ready=0: ignored, no error.
- Pipeline:
  - S1 at edge E0+1+c: register the sum over i of d[i]*W[c][phase][i], using full-precision signed products and sum width 2*DATA_W+$clog2(N_IN).
  - S2 at edge E0+2+c: acc[c] <= (phase==0 ? sum : acc[c]+sum), with ACC_W = sum width + $clog2(N_PHASE).
  - If last: at edge E0+2+c, valid=1, q_ch=c, q=post(acc_new). Otherwise valid=0.
- Back-to-back ops produce N_CH consecutive valid cycles with no gap beyond one cycle. No accumulator hazard exists because the same channel is never in S1 and S2 together.
- post(x):
  - r = (x + 2^(FRAC_W-1)) >>> FRAC_W (round half up, arithmetic shift).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat=1 if clipped.
  - Then, if RELU_MASK[cs_latched], negative results become 0. sat is preserved.
- Weights:
  - ws_load with ready=1 writes W[w_ch][w_phase] <= w_d at that edge.
  - ws_load with ready=0 is dropped and w_err pulses the next cycle.
  - ws_load and dc_load on the same idle edge: both accepted; the op uses the new weights.
- No output backpressure: the consumer must take valid pulses.

Decomposition:
- Shared package/include (alongside num_data/state_layer_data): `data_len`/FRAC constants, the layer ID defines, and the post() rounding/saturation width rules as macros/functions.
- One natural sub-module: dot_tree (N_IN multipliers plus a registered adder tree, latency 1), reusable by other engines.
- FSM, accumulator bank, weight buffer and post stage live in dot_channel_array.

Test Plan:
- All d=1.0 (18'h01000); W[c][0] = 0.5 for all c; phase=0, last=1, cs=0 -> after accept at E0, valid at E0+2..E0+5 with q_ch=0..3, q=18'h12000 (18.0), sat=0.
- Same weights on two ops, phase=0/last=0 then phase=1/last=1 -> first op gives no valid; second gives q=18'h1FFFF for every channel (36.0 saturates), sat=1.
- W=-0.5, cs=3: with RELU_MASK=0 -> q=18'h2E000 (-18.0); with RELU_MASK[3]=1 -> q=0, sat=0.
- Rounding with one nonzero input d[0]=18'h00001: W=0.5 -> q=1; W=-0.5 -> q=0.
- ws_load while ready=0 -> w_err=1 for one cycle and the weights are unchanged (a rerun gives identical q). dc_load during RUN -> ignored.
- rst asserted at E0+2 -> valid stays 0 afterwards. ready=1 the cycle after reset. Accumulators cleared, so a following phase=1/last=1 op yields only that op's sum.
